// File: rtl/count1k_timer_arb_pkg.sv
// Shared types and constants for the round-robin arbitrated 1k down-timer.
package count1k_timer_arb_pkg;

  localparam int unsigned CNT_W      = 10;
  localparam int unsigned MAXCNT_DEF = 999;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // A zero load would never expire, so it is promoted to one tick.
  function automatic logic [CNT_W-1:0] clamp_load(input logic [CNT_W-1:0] v,
                                                  input int unsigned maxcnt);
    logic [CNT_W-1:0] lim;
    lim = CNT_W'(maxcnt);
    if (v == '0)
      return CNT_W'(1);
    else if (v > lim)
      return lim;
    else
      return v;
  endfunction

endpackage

// File: rtl/count1k_down_core.sv
// Loadable down-counter with clear, enable-gated decrement and zero/last detect.
module count1k_down_core
  import count1k_timer_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] q,
  output logic             zero,
  output logic             last
);

  assign zero = (q == '0);
  assign last = (q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset || clr)
      q <= '0;
    else if (load)
      q <= load_val;
    else if (dec && !zero)
      q <= q - CNT_W'(1);
  end

endmodule

// File: rtl/count1k_timer_arb.sv
// Round-robin arbiter granting a single shared down-timer to NREQ requesters.
module count1k_timer_arb
  import count1k_timer_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned MAXCNT = MAXCNT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick_en,
  input  logic [NREQ-1:0]       req,
  input  logic [CNT_W*NREQ-1:0] load_val,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [CNT_W-1:0]      q
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    win;
  logic             found;
  int unsigned      idx;
  logic             core_load;
  logic             core_dec;
  logic             core_clr;
  logic [CNT_W-1:0] core_val;
  logic             zero;
  logic             last;
  logic             abort;
  logic             expire;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(rr_ptr) + k) % NREQ;
      if (!found && req[idx[PW-1:0]]) begin
        win   = idx[PW-1:0];
        found = 1'b1;
      end
    end
  end

  // q never sits at zero in RUN; treating it as an abort keeps the count from stalling.
  always_comb begin
    abort     = (state == RUN) && (!req[rr_ptr] || zero);
    core_load = (state == IDLE) && found;
    core_clr  = abort;
    core_dec  = (state == RUN) && !abort && tick_en;
    expire    = core_dec && last;
    core_val  = clamp_load(load_val[CNT_W*32'(win) +: CNT_W], MAXCNT);
  end

  count1k_down_core u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (core_load),
    .load_val (core_val),
    .dec      (core_dec),
    .clr      (core_clr),
    .q        (q),
    .zero     (zero),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      gnt    <= '0;
      done   <= '0;
      rr_ptr <= PW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt    <= NREQ'(1) << win;
            rr_ptr <= win;
            state  <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            gnt   <= '0;
            state <= IDLE;
          end else if (expire) begin
            done  <= gnt;
            state <= DONE;
          end
        end
        DONE: begin
          gnt   <= '0;
          done  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_count1k_timer_arb.sv
// Scoreboard bench for count1k_timer_arb: expected done pulses are queued at stimulus time.
module tb_count1k_timer_arb;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_en;
  logic [3:0]  req;
  logic [39:0] load_val;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [9:0]  q;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int gcyc     = 0;
  logic [3:0] prev_gnt = '0;

  typedef struct {
    logic [3:0] g;
    int         lat;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  count1k_timer_arb #(.NREQ(NREQ), .MAXCNT(999)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick_en  (tick_en),
    .req      (req),
    .load_val (load_val),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .q        (q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_load(input int i, input logic [9:0] v);
    load_val[10*i +: 10] = v;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 0);
      sb.delete();
    end
  endtask

  // Monitor: grant timestamps, done pulses against the scoreboard, one-hot invariants.
  always @(negedge clk) begin
    if (reset) begin
      prev_gnt = '0;
    end else begin
      check("gnt_onehot0", 32'($onehot0(gnt)), 1);
      check("done_onehot0", 32'($onehot0(done)), 1);
      if (gnt != '0 && prev_gnt == '0) gcyc = cyc;
      if (done != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 0);
        end else begin
          mon_e = sb.pop_front();
          check("done_vec", 32'(done), 32'(mon_e.g));
          check("done_gnt", 32'(gnt), 32'(done));
          check("latency", 32'(cyc - gcyc), 32'(mon_e.lat));
        end
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    tick_en  = 1'b0;
    req      = '0;
    load_val = '0;
    step();
    step();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_q", 32'(q), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;

    // Single requester, load 5
    set_load(0, 10'd5);
    tick_en = 1'b1;
    req = 4'b0001;
    sb.push_back('{4'b0001, 5});
    step();
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_q0", 32'(q), 5);
    check("t1_busy", 32'(busy), 1);
    for (int i = 4; i >= 0; i--) begin
      step();
      check("t1_q_step", 32'(q), 32'(i));
    end
    req = '0;
    step();
    check("t1_done_clr", 32'(done), 0);
    check("t1_gnt_clr", 32'(gnt), 0);
    check("t1_busy_low", 32'(busy), 0);
    check("t1_sb_empty", 32'(sb.size()), 0);

    // All four requesting, load 2 each: round-robin from requester 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    load_val = {4{10'd2}};
    req = 4'b1111;
    sb.push_back('{4'b0001, 2});
    sb.push_back('{4'b0010, 2});
    sb.push_back('{4'b0100, 2});
    sb.push_back('{4'b1000, 2});
    sb.push_back('{4'b0001, 2});
    drain(100);
    req = '0;
    step();
    step();
    check("rr_busy_low", 32'(busy), 0);

    // Load 0 clamps to 1
    set_load(0, 10'd0);
    req = 4'b0001;
    sb.push_back('{4'b0001, 1});
    step();
    check("clamp0_q", 32'(q), 1);
    drain(10);
    req = '0;
    step();
    step();

    // Load 1023 clamps to 999
    set_load(0, 10'd1023);
    req = 4'b0001;
    sb.push_back('{4'b0001, 999});
    step();
    check("clampmax_q", 32'(q), 999);
    drain(1100);
    req = '0;
    step();
    step();

    // tick_en alternating 0/1 doubles latency for load 5
    set_load(0, 10'd5);
    req = 4'b0001;
    sb.push_back('{4'b0001, 10});
    step();
    for (int i = 0; i < 30 && sb.size() != 0; i++) begin
      tick_en = (i % 2 == 1);
      step();
    end
    check("toggle_drain", 32'(sb.size()), 0);
    sb.delete();
    tick_en = 1'b1;
    req = '0;
    step();
    step();

    // Abort by dropping req0 with q=3
    set_load(0, 10'd6);
    req = 4'b0001;
    step();
    check("abort_q_load", 32'(q), 6);
    step();
    step();
    step();
    check("abort_q3", 32'(q), 3);
    req = '0;
    step();
    check("abort_gnt", 32'(gnt), 0);
    check("abort_q", 32'(q), 0);
    check("abort_done", 32'(done), 0);
    check("abort_busy", 32'(busy), 0);
    step();
    check("abort_no_done", 32'(done), 0);

    // Reset in mid-run, then priority restored to requester 0 side
    set_load(0, 10'd600);
    req = 4'b0001;
    step();
    repeat (100) step();
    check("midrun_q500", 32'(q), 500);
    reset = 1'b1;
    step();
    check("midrst_q", 32'(q), 0);
    check("midrst_gnt", 32'(gnt), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_busy", 32'(busy), 0);
    reset = 1'b0;
    set_load(1, 10'd3);
    set_load(3, 10'd3);
    req = 4'b1010;
    sb.push_back('{4'b0010, 3});
    sb.push_back('{4'b1000, 3});
    step();
    check("postrst_gnt", 32'(gnt), 32'h2);
    // Others toggling must not disturb requester 1's timer
    req = 4'b1011;
    step();
    req = 4'b1110;
    step();
    req = 4'b1010;
    drain(40);
    req = '0;
    step();
    step();
    check("final_busy", 32'(busy), 0);
    check("final_sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/count1k_timer_arb.md
COUNT1K_TIMER_ARB -- requirements
Module: count1k_timer_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing the timer.
REQ-002 SHALL have parameter MAXCNT, default 999: largest loadable count.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-005 SHALL have port tick_en, input, 1: count enable (prescaler strobe).
REQ-006 SHALL have port req, input, NREQ: per-requester timer request, level-held.
REQ-007 SHALL have port load_val, input, 10*NREQ: requester i's count in bits [10*i+9:10*i].
REQ-008 SHALL have port gnt, output, NREQ: one-hot grant, registered.
REQ-009 SHALL have port done, output, NREQ: one-cycle expiry pulse to the granted requester, registered.
REQ-010 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-011 SHALL have port q, output, 10: current remaining count, registered.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE.
REQ-013 IDLE with req==0 SHALL hold; with req!=0 SHALL grant in one edge: winner = first set req bit searching from rr_ptr+1 upward, modulo NREQ.
REQ-014 On grant SHALL set gnt to onehot(winner), rr_ptr to winner, and q to the load value clamped: 0 -> 1, >MAXCNT -> MAXCNT; next state RUN.
REQ-015 RUN SHALL decrement q by 1 on each edge with tick_en=1 and hold q when tick_en=0.
REQ-016 RUN with q==1 and tick_en=1 SHALL set q to 0, assert done[winner], and enter DONE on that edge.
REQ-017 DONE SHALL last exactly one cycle, then clear gnt and done and return to IDLE; a grant takes at least one further edge.
REQ-018 RUN with req[winner]==0 SHALL abort: gnt cleared, q to 0, no done pulse, next state IDLE; abort takes precedence over expiry on the same edge.
REQ-019 req changes of non-granted requesters during RUN/DONE SHALL NOT affect the active timer.
REQ-020 A requester holding req after done SHALL be re-eligible, but only after others at higher round-robin priority.
REQ-021 Grant-to-done latency SHALL equal the clamped load value in tick_en=1 cycles; with tick_en held 1 and load N, done is high N edges after the grant edge.
REQ-022 gnt and done SHALL each be zero or one-hot at all times; done SHALL be high only in DONE.

Reset
REQ-023 reset=1 at an edge SHALL force state IDLE, gnt=0, done=0, q=0, and rr_ptr=NREQ-1, so requester 0 has top priority.
REQ-024 reset SHALL override every other input, including mid-RUN and in DONE; an aborted run produces no done pulse.
REQ-025 Outputs SHALL be known (no X) from the first edge with reset=1.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, RUN, DONE), CNT_W=10, and the default MAXCNT=999.
REQ-027 The down-counter (load, decrement on enable, clear, zero-detect) SHALL be a sub-module named count1k_down_core.
REQ-028 The round-robin winner search SHALL be combinational inside count1k_timer_arb.

Verification
REQ-029 Reset, then req=0001, load0=5, tick_en=1 -> gnt=0001 next edge; q steps 5,4,3,2,1,0; done=0001 for exactly one cycle; busy low after.
REQ-030 req=1111, all loads=2, tick_en=1, req held -> grant order 0,1,2,3,0; each done pulse matches the active gnt.
REQ-031 load0=0 -> q=1, done after 1 tick; load0=1023 -> q=999 and done after 999 ticks; tick_en toggling 1/0 doubles the latency to 10 cycles for load 5.
REQ-032 req0 dropped with q=3 in RUN -> next edge gnt=0, q=0, no done pulse, state IDLE.
REQ-033 reset=1 during RUN with q=500 -> next edge q=0, gnt=0, done=0, busy=0; after reset with req=1010, requester 1 is granted first.
